// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
package lsu_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } lsu_state_e;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic half;
    logic word;
    half = (f3 == F3_H) || (f3 == F3_HU);
    word = (f3 == F3_W);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction

  // Store byte enables; unsupported sizes write nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << a;
      F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {4{d[7:0]}};
      F3_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Select and sign/zero-extend the addressed lane of a memory word.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = w;
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_be.sv
// Word array with synchronous byte-enabled write and combinational read.
module data_mem_be #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr_i,
  input  logic [31:0]                  wdata_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  // Byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage_lsu.sv
// E->M pipeline register plus RV32I load/store unit with optional wait states.
module memory_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_DEPTH     = 1024,
  parameter int unsigned MEM_LATENCY   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write_e,
  input  logic [1:0]               result_src_e,
  input  logic                     mem_write_e,
  input  logic                     mem_read_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  input  logic                     flush_m,
  output logic                     stall_m,
  output logic                     reg_write_m,
  output logic [1:0]               result_src_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic [4:0]               rd_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  output logic                     misaligned_m
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam logic [3:0]  Lat  = 4'(MEM_LATENCY);

  logic                     reg_write_q, mem_write_q, mem_read_q;
  logic [1:0]               result_src_q;
  logic [2:0]               funct3_q;
  logic [DATA_WIDTH-1:0]    alu_result_q, write_data_q;
  logic [4:0]               rd_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q;

  lsu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_lat_q;
  logic        commit;
  logic        mem_op_e;
  logic        mem_we;
  logic [31:0] mem_rdata, load_fmt;

  assign mem_op_e = (mem_read_e | mem_write_e) & ~is_misaligned(funct3_e, alu_result_e[1:0]);

  // Pipeline register: hold while stalled, otherwise capture E or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
    end else if (!stall_m) begin
      if (flush_m) begin
        reg_write_q  <= 1'b0;
        result_src_q <= '0;
        mem_write_q  <= 1'b0;
        mem_read_q   <= 1'b0;
        funct3_q     <= '0;
        alu_result_q <= '0;
        write_data_q <= '0;
        rd_q         <= '0;
        pc_plus4_q   <= '0;
      end else begin
        reg_write_q  <= reg_write_e;
        result_src_q <= result_src_e;
        mem_write_q  <= mem_write_e;
        mem_read_q   <= mem_read_e;
        funct3_q     <= funct3_e;
        alu_result_q <= alu_result_e;
        write_data_q <= write_data_e;
        rd_q         <= rd_e;
        pc_plus4_q   <= pc_plus4_e;
      end
    end
  end

  // Wait-state FSM state, counter and formatted load-data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rdata_lat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && mem_read_q) rdata_lat_q <= load_fmt;
    end
  end

  // Next-state: a new aligned memory op enters BUSY; the last wait cycle commits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if ((MEM_LATENCY != 0) && !flush_m && mem_op_e) begin
          state_d = StBusy;
          cnt_d   = Lat;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
          commit  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign misaligned_m = (mem_read_q | mem_write_q) & is_misaligned(funct3_q, alu_result_q[1:0]);
  assign stall_m      = (MEM_LATENCY != 0) && (state_q == StBusy);

  // Zero latency commits on every M exit; otherwise only on the final wait edge.
  assign mem_we = (MEM_LATENCY == 0) ? (mem_write_q & ~misaligned_m) : (commit & mem_write_q);

  data_mem_be #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .be_i   (byte_en(funct3_q, alu_result_q[1:0])),
    .addr_i (alu_result_q[IdxW+1:2]),
    .wdata_i(store_data(funct3_q, write_data_q)),
    .rdata_o(mem_rdata)
  );

  assign load_fmt = load_format(funct3_q, alu_result_q[1:0], mem_rdata);

  // Load data: combinational at zero latency, from the latch in DONE otherwise.
  always_comb begin
    read_data_m = '0;
    if (MEM_LATENCY == 0) begin
      if (mem_read_q && !misaligned_m) read_data_m = load_fmt;
    end else if ((state_q == StDone) && mem_read_q) begin
      read_data_m = rdata_lat_q;
    end
  end

  assign reg_write_m  = reg_write_q & ~misaligned_m;
  assign result_src_m = result_src_q;
  assign alu_result_m = alu_result_q;
  assign rd_m         = rd_q;
  assign pc_plus4_m   = pc_plus4_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench: a zero-latency and a three-wait-state instance share one stimulus.
module tb_memory_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        reg_write_e, mem_write_e, mem_read_e, flush_m;
  logic [1:0]  result_src_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
  logic [4:0]  rd_e;

  logic        stall0, reg_write0, mis0;
  logic [1:0]  rsrc0;
  logic [31:0] alu0, read0, pc0;
  logic [4:0]  rd0;

  logic        stall3, reg_write3, mis3;
  logic [1:0]  rsrc3;
  logic [31:0] alu3, read3, pc3;
  logic [4:0]  rd3;

  int n_checks = 0;
  int n_fail   = 0;
  int stall0_seen = 0;

  memory_stage_lsu #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_DEPTH(1024), .MEM_LATENCY(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .funct3_e(funct3_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
    .pc_plus4_e(pc_plus4_e), .flush_m(flush_m), .stall_m(stall0), .reg_write_m(reg_write0),
    .result_src_m(rsrc0), .alu_result_m(alu0), .read_data_m(read0), .rd_m(rd0),
    .pc_plus4_m(pc0), .misaligned_m(mis0)
  );

  memory_stage_lsu #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_DEPTH(1024), .MEM_LATENCY(3)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .funct3_e(funct3_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
    .pc_plus4_e(pc_plus4_e), .flush_m(flush_m), .stall_m(stall3), .reg_write_m(reg_write3),
    .result_src_m(rsrc3), .alu_result_m(alu3), .read_data_m(read3), .rd_m(rd3),
    .pc_plus4_m(pc3), .misaligned_m(mis3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The zero-latency instance must never raise stall.
  always @(negedge clk) if (stall0 !== 1'b0) stall0_seen++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_e(input logic rw, input logic mw, input logic mr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    reg_write_e  = rw;
    mem_write_e  = mw;
    mem_read_e   = mr;
    result_src_e = mr ? 2'b01 : 2'b00;
    funct3_e     = f3;
    alu_result_e = addr;
    write_data_e = wd;
    rd_e         = rd;
    pc_plus4_e   = 32'h1000_0000 | addr;
    flush_m      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic mw, input logic mr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    set_e(rw, mw, mr, f3, addr, wd, rd);
    step();
  endtask

  task automatic wait_idle3(input string tag);
    int n;
    n = 0;
    while (stall3 && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_timeout"}, {31'h0, stall3}, 32'h0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    #2;
    check_eq("rst_stall0", {31'h0, stall0}, 32'h0);
    check_eq("rst_regw0", {31'h0, reg_write0}, 32'h0);
    check_eq("rst_alu0", alu0, 32'h0);
    check_eq("rst_pc0", pc0, 32'h0);
    check_eq("rst_read3", read3, 32'h0);
    check_eq("rst_stall3", {31'h0, stall3}, 32'h0);
    #10 rst_n = 1'b1;
    step();

    // ---- zero-latency instance ----
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'hABCD_1234, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd5);
    check_eq("lw_word", read0, 32'hABCD_1234);
    check_eq("lw_mis", {31'h0, mis0}, 32'h0);
    check_eq("lw_regw", {31'h0, reg_write0}, 32'h1);
    check_eq("lw_rd", {27'h0, rd0}, 32'd5);
    check_eq("lw_rsrc", {30'h0, rsrc0}, 32'd1);

    issue(1'b0, 1'b1, 1'b0, 3'b000, 32'h101, 32'h0000_00FF, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 3'b000, 32'h101, 32'h0, 5'd6);
    check_eq("lb_sext", read0, 32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 1'b1, 3'b100, 32'h101, 32'h0, 5'd6);
    check_eq("lbu_zext", read0, 32'h0000_00FF);
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd6);
    check_eq("lw_after_sb", read0, 32'hABCD_FF34);

    issue(1'b0, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0000_8001, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 5'd7);
    check_eq("lh_sext", read0, 32'hFFFF_8001);
    issue(1'b1, 1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 5'd7);
    check_eq("lhu_zext", read0, 32'h0000_8001);

    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 5'd8);
    check_eq("mis_lw_flag", {31'h0, mis0}, 32'h1);
    check_eq("mis_lw_regw", {31'h0, reg_write0}, 32'h0);
    check_eq("mis_lw_data", read0, 32'h0);
    check_eq("mis_lw_stall", {31'h0, stall0}, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h102, 32'hDEAD_BEEF, 5'd0);
    check_eq("mis_sw_flag", {31'h0, mis0}, 32'h1);
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd8);
    check_eq("mis_no_write", read0, 32'h8001_FF34);

    issue(1'b1, 1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 5'd8);
    check_eq("bad_f3_load", read0, 32'h0);

    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h1000, 32'h1357_9BDF, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 5'd9);
    check_eq("alias_wrap", read0, 32'h1357_9BDF);

    issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3);
    check_eq("alu_pass", alu0, 32'h55);
    check_eq("pc_pass", pc0, 32'h1000_0055);
    check_eq("alu_noload", read0, 32'h0);
    set_e(1'b1, 1'b0, 1'b0, 3'b000, 32'h66, 32'h0, 5'd3);
    flush_m = 1'b1;
    step();
    check_eq("flush_regw", {31'h0, reg_write0}, 32'h0);
    check_eq("flush_alu", alu0, 32'h0);
    check_eq("lat0_no_stall", stall0_seen, 0);

    // ---- three-wait-state instance ----
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd4);
    check_eq("nonmem_stall3", {31'h0, stall3}, 32'h0);
    check_eq("nonmem_alu3", alu3, 32'h77);

    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h200, 32'hCAFE_F00D, 5'd0);
    check_eq("sw_stall3", {31'h0, stall3}, 32'h1);
    set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    wait_idle3("sw3");
    step();

    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 5'd7);
    n = 0;
    while (stall3 && n < 20) begin
      check_eq("hold_alu3", alu3, 32'h200);
      set_e(1'b1, 1'b0, 1'b0, 3'b010, 32'hDEAD_0000, 32'h0, 5'd9);
      flush_m = (n == 1);
      step();
      n++;
    end
    set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    check_eq("stall_cycles", n, 3);
    check_eq("done_data3", read3, 32'hCAFE_F00D);
    check_eq("done_stall3", {31'h0, stall3}, 32'h0);
    check_eq("done_rd3", {27'h0, rd3}, 32'd7);
    check_eq("done_regw3", {31'h0, reg_write3}, 32'h1);
    step();

    // Store then load of the same word, load held upstream during the stall.
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h204, 32'h2468_1357, 5'd0);
    set_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h204, 32'h0, 5'd2);
    wait_idle3("b2b_sw");
    step();
    check_eq("b2b_busy", {31'h0, stall3}, 32'h1);
    set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    wait_idle3("b2b_lw");
    check_eq("b2b_data", read3, 32'h2468_1357);
    step();

    // Reset in the middle of a store's wait states.
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h200, 32'h1111_1111, 5'd0);
    set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_stall3", {31'h0, stall3}, 32'h0);
    check_eq("midrst_alu3", alu3, 32'h0);
    check_eq("midrst_read3", read3, 32'h0);
    #1 rst_n = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 5'd1);
    set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    wait_idle3("midrst_lw");
    check_eq("midrst_unchanged", read3, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage_lsu.md
Name: memory_stage_lsu

Overview:
Parametrised successor to the 3-stage core's memory stage. Holds the E->M pipeline register and a byte-addressable data memory with a full RV32I load/store unit: byte/half/word stores with byte enables, and sign/zero-extended loads. Adds configurable memory wait states with a stall output to the hazard unit, bubble insertion (flush) and misaligned-access detection. Sits between the execute stage and writeback.

Parameters:
DATA_WIDTH, 32, data path width; only 32 is supported.
ADDRESS_WIDTH, 32, byte address and PC width.
MEM_DEPTH, 1024, number of DATA_WIDTH words in the data memory; must be a power of 2.
MEM_LATENCY, 0, number of wait-state cycles per load/store (0..15).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
reg_write_e  in  1  register write enable from execute
result_src_e  in  2  writeback mux select from execute
mem_write_e  in  1  store enable
mem_read_e  in  1  load enable
funct3_e  in  3  load/store size and sign (instr[14:12])
alu_result_e  in  DATA_WIDTH  effective byte address / ALU result
write_data_e  in  DATA_WIDTH  store data (rs2)
rd_e  in  5  destination register
pc_plus4_e  in  ADDRESS_WIDTH  PC+4
flush_m  in  1  load a bubble into M instead of the E inputs
stall_m  out  1  M busy; upstream must hold
reg_write_m  out  1  registered, gated by misalign
result_src_m  out  2  registered
alu_result_m  out  DATA_WIDTH  registered
read_data_m  out  DATA_WIDTH  formatted load data
rd_m  out  5  registered
pc_plus4_m  out  ADDRESS_WIDTH  registered
misaligned_m  out  1  M instruction is a misaligned load/store

Behaviour:
- Reset (rst_n low, asynchronous): all M registers 0, FSM IDLE, wait counter 0, latched read data 0. So all outputs are 0, including stall_m. Memory array contents are not reset.
- Pipeline register: at a rising edge with stall_m low, capture the E inputs. If flush_m is high, capture all zeros instead. While stall_m is high, hold M and ignore flush_m.
- Word index: alu_result_m[log2(MEM_DEPTH)+1:2]. Upper address bits are ignored, so the array wraps modulo MEM_DEPTH words.
- Stores, by funct3:
  - 000 SB: write data[7:0] into the byte lane addr[1:0].
  - 001 SH: write data[15:0] into the half addr[1].
  - 010 SW: full word.
  - Other funct3 values: no write.
- Loads, by funct3:
  - 000 LB and 001 LH: sign-extend the selected lane.
  - 010 LW: full word.
  - 100 LBU and 101 LHU: zero-extend the selected lane.
  - Other funct3 values: read_data_m is 0.
- read_data_m is 0 whenever M holds no load.
- Misaligned: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - misaligned_m=1 and no memory write.
  - reg_write_m is forced to 0 and read_data_m is 0.
  - No wait states are spent.
- MEM_LATENCY=0:
  - No stall.
  - Load data is a combinational read of the array.
  - A store commits at the edge that moves the instruction out of M.
- MEM_LATENCY=N>0, FSM states IDLE, BUSY, DONE:
  - IDLE -> BUSY: a valid aligned load/store is captured into M; cnt=N. stall_m = (state==BUSY).
  - In BUSY, cnt decrements each edge.
  - At the edge where cnt==1: the store commits; the load word is latched and sign/zero-formatted; state goes to DONE.
  - DONE has stall low and read_data_m valid from the latch. The next edge captures the next E instruction and goes to BUSY if that instruction is also a memory op, otherwise IDLE.
  - A memory op therefore occupies M for N+1 cycles, with stall_m high for N.
- A non-memory instruction never stalls.
- Back-to-back memory ops: a load immediately following a store to the same word returns the new data.
- Reset mid-BUSY: the access is abandoned; a pending store is not committed.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 encodings: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: IDLE, BUSY, DONE.
  - Byte-enable and load-format functions.
- One sub-module, data_mem_be: a synchronous-write, combinational-read word array with 4 byte enables, parametrised by MEM_DEPTH.

Test Plan:
- Reset, then SW 0xABCD1234 to 0x00000100, then LW from 0x100 -> read_data_m=0xABCD1234, misaligned_m=0. With LAT=0, stall_m is never high.
- Continuing from the word above: SB 0x000000FF to 0x101, then LB 0x101 -> 0xFFFFFFFF, LBU 0x101 -> 0x000000FF, LW 0x100 -> 0xABCDFF34.
- SH 0x00008001 to 0x102, then LH 0x102 -> 0xFFFF8001, LHU 0x102 -> 0x00008001.
- LW at 0x00000102 with reg_write_e=1 -> misaligned_m=1, reg_write_m=0, read_data_m=0, stall_m=0, memory unchanged.
- MEM_LATENCY=3: LW captured -> stall_m high for exactly 3 cycles. The E inputs are changed during the stall and M still holds the LW. read_data_m is valid in the following DONE cycle. flush_m asserted during the stall is ignored.
- MEM_DEPTH=1024: SW to 0x00001000 aliases 0x0 (LW 0x0 returns the stored value). rst_n pulsed low mid-BUSY of an SW -> outputs are 0 immediately and the target word is unchanged.
